apb_wait_mem_slave: RTL
=======================

// Module: apb_wait_mem_slave
// PURPOSE
//  Parametrised APB3/APB4 completer fronting an on-chip word memory.
//  Successor to the fixed APB slave: programmable wait states, PSLVERR on bad address, byte strobes.
//  Sits behind the APB bridge as a scratch/config RAM; one completer per p_sel.
// PARAMETERS
//  A_WIDTH    8     byte address width
//  D_WIDTH    32    data width; multiple of 8, power of two
//  DEPTH      16    number of D_WIDTH words; power of two, DEPTH*D_WIDTH/8 <= 2**A_WIDTH
//  WAIT_W     4     width of wait_cfg; max wait states = 2**WAIT_W-1
//  RESET_VAL  'h0   reset value of p_rdata
// PORTS
//  p_clk     in   1            clock, all state on rising edge
//  p_rstn    in   1            asynchronous active-low reset
//  p_sel     in   1            completer select
//  p_enable  in   1            access phase
//  p_write   in   1            1=write, 0=read
//  p_addr    in   A_WIDTH      byte address
//  p_wdata   in   D_WIDTH      write data
//  p_strb    in   D_WIDTH/8    write byte strobes
//  wait_cfg  in   WAIT_W       wait states inserted per transfer (quasi-static)
//  p_rdata   out  D_WIDTH      read data, valid while p_ready=1 on a read
//  p_ready   out  1            transfer completes this cycle
//  p_slverr  out  1            error response, valid only while p_ready=1
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, p_ready=0, p_slverr=0, p_rdata=RESET_VAL, wait counter=0.
//   Memory array not reset.
//  Outputs registered. idx = p_addr >> log2(D_WIDTH/8).
//  FSM states: IDLE, WAIT, RESP.
//  IDLE:
//   - On setup (p_sel & !p_enable), latch addr/write/wdata/strb and wait_cfg.
//   - wait_cfg==0 -> RESP, p_ready=1 next cycle (zero-wait: ready in the first access cycle).
//   - else -> WAIT, cnt=wait_cfg-1.
//  WAIT:
//   - !p_sel -> IDLE (aborted transfer, no write).
//   - cnt==0 -> RESP, p_ready=1.
//   - else cnt--.
//   - Total access-phase length = wait_cfg+1 cycles.
//  RESP:
//   - p_ready=1 for exactly one cycle, then IDLE with p_ready=0.
//   - Back-to-back setup accepted in the cycle after RESP.
//  Error: slverr = (idx >= DEPTH) | (p_addr low log2(D_WIDTH/8) bits != 0), evaluated on entering RESP.
//  Read: p_rdata = error ? 0 : mem[idx], loaded on entry to RESP and held until the next RESP.
//  Write: commits at the RESP clock edge when p_sel & p_enable & p_write & !slverr.
//   - An error write leaves memory unchanged.
//   - A write followed immediately by a read of the same idx returns the new data.
//  Protocol-error case: p_enable high in IDLE without a prior setup is ignored (no transfer).
//  Reset mid-transfer: p_ready drops immediately (async); a pending write is discarded.
// CONFIGURATION
//  APB_WAIT_STRB_EN defined: write updates only bytes with p_strb[i]=1; p_strb==0 is a no-op write with OKAY.
//  Undefined: p_strb ignored; every write updates the full word (APB3 behaviour).
// STRUCTURE
//  Package apb_wait_mem_pkg:
//   - state enum typedef {IDLE, WAIT, RESP}
//   - localparam functions for byte-lane count and index shift
//   - RESP_OKAY / RESP_ERR constants
//  One sub-module: apb_wait_mem_array (DEPTH x D_WIDTH, byte-enable write port, sync-registered read).
//   FSM and error logic stay in the top module.
// TESTING
//  1. Reset asserted mid-WAIT (wait_cfg=5) -> p_ready=0 and p_rdata=RESET_VAL immediately; memory at written idx unchanged.
//  2. wait_cfg=0: write 0xDEADBEEF @0x04, then read @0x04 -> p_ready in the first access cycle; read returns 0xDEADBEEF, slverr=0.
//  3. wait_cfg=3: read @0x08 -> p_ready high on the 4th access cycle only; p_enable held throughout.
//  4. Write @0x40 (idx=16, DEPTH=16) and write @0x05 (misaligned) -> slverr=1 with ready; a subsequent read of idx 0/1 shows no change; error read returns 0.
//  5. With APB_WAIT_STRB_EN: word=0x11223344, write 0xAABBCCDD with p_strb=4'b0101 -> read 0x11BB33DD; without the macro -> read 0xAABBCCDD.
//  6. Back-to-back write then read, same idx, no idle gap -> read returns new data; p_sel dropped in WAIT -> FSM returns to IDLE, no write occurs.

Source files
------------

// File: rtl/apb_wait_mem_pkg.sv
// Shared types and helpers for the wait-state APB memory completer.
package apb_wait_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic RESP_OKAY = 1'b0;
    localparam logic RESP_ERR  = 1'b1;

    function automatic int lane_count(input int dw);
        return dw / 8;
    endfunction

    function automatic int idx_shift(input int dw);
        return $clog2(dw / 8);
    endfunction

endpackage

// File: rtl/apb_wait_mem_array.sv
// DEPTH x D_WIDTH word store with byte-enable write port and registered read.
module apb_wait_mem_array
    import apb_wait_mem_pkg::*;
#(
    parameter int                 DEPTH     = 16,
    parameter int                 D_WIDTH   = 32,
    parameter logic [D_WIDTH-1:0] RESET_VAL = '0,
    localparam int                AW        = $clog2(DEPTH),
    localparam int                LANES     = lane_count(D_WIDTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               we,
    input  logic [AW-1:0]      waddr,
    input  logic [D_WIDTH-1:0] wdata,
    input  logic [LANES-1:0]   wbe,
    input  logic               re,
    input  logic               rzero,
    input  logic [AW-1:0]      raddr,
    output logic [D_WIDTH-1:0] rdata
);

    logic [D_WIDTH-1:0] mem_r [DEPTH];

    // Byte-lane write port; the array itself is deliberately not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < LANES; i++) begin
                if (wbe[i]) begin
                    mem_r[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
                end
            end
        end
    end

    // Read register doubles as the bus read-data output; error reads return zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= RESET_VAL;
        end else if (re) begin
            rdata <= rzero ? {D_WIDTH{1'b0}} : mem_r[raddr];
        end
    end

endmodule

// File: rtl/apb_wait_mem_slave.sv
// APB3/APB4 completer with programmable wait states, PSLVERR and an on-chip word RAM.
// Define APB_WAIT_STRB_EN to honour p_strb byte strobes; otherwise writes are full-word.
module apb_wait_mem_slave
    import apb_wait_mem_pkg::*;
#(
    parameter int                 A_WIDTH   = 8,
    parameter int                 D_WIDTH   = 32,
    parameter int                 DEPTH     = 16,
    parameter int                 WAIT_W    = 4,
    parameter logic [D_WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                   p_clk,
    input  logic                   p_rstn,
    input  logic                   p_sel,
    input  logic                   p_enable,
    input  logic                   p_write,
    input  logic [A_WIDTH-1:0]     p_addr,
    input  logic [D_WIDTH-1:0]     p_wdata,
    input  logic [D_WIDTH/8-1:0]   p_strb,
    input  logic [WAIT_W-1:0]      wait_cfg,
    output logic [D_WIDTH-1:0]     p_rdata,
    output logic                   p_ready,
    output logic                   p_slverr
);

    localparam int          LANES    = lane_count(D_WIDTH);
    localparam int          SHIFT    = idx_shift(D_WIDTH);
    localparam int          AW       = $clog2(DEPTH);
    localparam logic [31:0] LOW_MASK = (32'd1 << SHIFT) - 32'd1;

    state_t               state_r, state_nxt_s;
    logic [WAIT_W-1:0]    cnt_r, cnt_nxt_s;
    logic                 setup_s, enter_resp_s;
    logic [A_WIDTH-1:0]   addr_r, cur_addr_s;
    logic                 write_r, cur_write_s;
    logic [D_WIDTH-1:0]   wdata_r;
    logic [LANES-1:0]     strb_r, wbe_s;
    logic [31:0]          idx_s;
    logic                 err_s, we_s, re_s;

    // Next-state and wait counter decode.
    always_comb begin
        state_nxt_s  = state_r;
        cnt_nxt_s    = cnt_r;
        setup_s      = 1'b0;
        enter_resp_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (p_sel && !p_enable) begin
                    setup_s = 1'b1;
                    if (wait_cfg == {WAIT_W{1'b0}}) begin
                        state_nxt_s  = RESP;
                        enter_resp_s = 1'b1;
                    end else begin
                        state_nxt_s = WAIT;
                        cnt_nxt_s   = wait_cfg - WAIT_W'(1);
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            WAIT: begin
                if (!p_sel) begin
                    state_nxt_s = IDLE;
                    cnt_nxt_s   = {WAIT_W{1'b0}};
                end else if (cnt_r == {WAIT_W{1'b0}}) begin
                    state_nxt_s  = RESP;
                    enter_resp_s = 1'b1;
                end else begin
                    cnt_nxt_s = cnt_r - WAIT_W'(1);
                end
            end
            RESP: begin
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
                cnt_nxt_s   = {WAIT_W{1'b0}};
            end
        endcase
    end

    // Zero-wait transfers enter RESP straight from IDLE, before the latches are loaded.
    always_comb begin
        if (state_r == IDLE) begin
            cur_addr_s  = p_addr;
            cur_write_s = p_write;
        end else begin
            cur_addr_s  = addr_r;
            cur_write_s = write_r;
        end
    end

    // Address decode: out-of-range word index or misaligned byte address.
    always_comb begin
        idx_s = 32'(cur_addr_s) >> SHIFT;
        err_s = (idx_s >= 32'(DEPTH)) || ((32'(cur_addr_s) & LOW_MASK) != 32'd0);
    end

    // Write commits at the completing edge; read is captured on entry to RESP.
    always_comb begin
        we_s = (state_r == RESP) && p_sel && p_enable && p_write && (p_slverr == RESP_OKAY);
        re_s = enter_resp_s && !cur_write_s;
`ifdef APB_WAIT_STRB_EN
        wbe_s = strb_r;
`else
        wbe_s = strb_r | {LANES{1'b1}};
`endif
    end

    // FSM state, wait counter, response flags and setup-phase latches.
    always_ff @(posedge p_clk or negedge p_rstn) begin
        if (!p_rstn) begin
            state_r  <= IDLE;
            cnt_r    <= {WAIT_W{1'b0}};
            p_ready  <= 1'b0;
            p_slverr <= RESP_OKAY;
            addr_r   <= {A_WIDTH{1'b0}};
            write_r  <= 1'b0;
            wdata_r  <= {D_WIDTH{1'b0}};
            strb_r   <= {LANES{1'b0}};
        end else begin
            state_r  <= state_nxt_s;
            cnt_r    <= cnt_nxt_s;
            p_ready  <= enter_resp_s;
            p_slverr <= (enter_resp_s && err_s) ? RESP_ERR : RESP_OKAY;
            if (setup_s) begin
                addr_r  <= p_addr;
                write_r <= p_write;
                wdata_r <= p_wdata;
                strb_r  <= p_strb;
            end
        end
    end

    apb_wait_mem_array #(
        .DEPTH     (DEPTH),
        .D_WIDTH   (D_WIDTH),
        .RESET_VAL (RESET_VAL)
    ) u_array (
        .clk   (p_clk),
        .rst_n (p_rstn),
        .we    (we_s),
        .waddr (AW'(addr_r >> SHIFT)),
        .wdata (wdata_r),
        .wbe   (wbe_s),
        .re    (re_s),
        .rzero (err_s),
        .raddr (idx_s[AW-1:0]),
        .rdata (p_rdata)
    );

endmodule
